tone_detect: RTL and testbench



---
 rtl/tone_detect.sv | 165 ++++++++++++++++
 tb/tb_tone_detect.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_detect.sv
// tone_detect: measures half-periods of an external square wave and reports
// a stable 440 Hz (low) or 880 Hz (high) tone.
// Optional feature macro: TONE_GLITCH_FILTER_EN -- when defined, edges that
// arrive less than MIN_HALF cycles after the previous accepted edge are ignored.
// CNT_W sets the half-period counter width (17 bits covers the default tones);
// the counter saturates at all-ones, which also sets the silence timeout.
module tone_detect #(
  parameter int CNT_W      = 17,
  parameter int HALF_LO    = 113636,
  parameter int HALF_HI    = 56818,
  parameter int TOL        = 2048,
  parameter int STABLE_CNT = 4,
  parameter int MIN_HALF   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic             tone_valid,
  output logic             tone_hi,
  output logic [CNT_W-1:0] half_period,
  output logic             tone_change
);

  localparam int MC_W = $clog2(STABLE_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HALF_LO_C = CNT_W'(HALF_LO);
  localparam logic [CNT_W-1:0] HALF_HI_C = CNT_W'(HALF_HI);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [MC_W-1:0]  STABLE_C  = MC_W'(STABLE_CNT);

  localparam logic [1:0] ST_SILENT  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_LO   = 2'd1;
  localparam logic [1:0] CLS_HI   = 2'd2;

  logic             sync1, sync2, sync_prev;
  logic             edge_raw, edge_ok;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] diff_lo, diff_hi;
  logic [1:0]       cls;
  logic [1:0]       state, state_n;
  logic [1:0]       cand, cand_n;
  logic [MC_W-1:0]  mc, mc_n;
  logic             lock_hi, lock_hi_n;
  logic [CNT_W-1:0] hp_n;

  // Two-flop synchronizer plus a delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, exactly as the hardware does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= tone_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign edge_raw = sync2 ^ sync_prev;

`ifdef TONE_GLITCH_FILTER_EN
  assign edge_ok = edge_raw && (cnt >= CNT_W'(MIN_HALF));
`else
  assign edge_ok = edge_raw;
`endif

  // Half-period counter: restarts at 1 on an accepted edge so the value seen
  // at the next edge equals the exact cycle distance; saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (edge_ok)       cnt <= CNT_W'(1);
    else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

  // Classify the current count against both tone windows.
  always_comb begin
    diff_lo = (cnt >= HALF_LO_C) ? (cnt - HALF_LO_C) : (HALF_LO_C - cnt);
    diff_hi = (cnt >= HALF_HI_C) ? (cnt - HALF_HI_C) : (HALF_HI_C - cnt);
    if (diff_lo <= TOL_C)      cls = CLS_LO;
    else if (diff_hi <= TOL_C) cls = CLS_HI;
    else                       cls = CLS_NONE;
  end

  // Detector FSM: SILENT -> ACQUIRE -> LOCKED, with silence timeout.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    cand_n    = cand;
    mc_n      = mc;
    lock_hi_n = lock_hi;
    hp_n      = half_period;
    if (edge_ok) begin
      case (state)
        ST_SILENT: begin
          // First edge only starts the counter.
          state_n = ST_ACQUIRE;
          cand_n  = CLS_NONE;
          mc_n    = '0;
        end
        ST_ACQUIRE: begin
          hp_n = cnt;
          if (cls == cand && cls != CLS_NONE) begin
            mc_n = mc + MC_W'(1);
          end else begin
            cand_n = cls;
            mc_n   = (cls != CLS_NONE) ? MC_W'(1) : '0;
          end
          if (mc_n == STABLE_C) begin
            state_n   = ST_LOCKED;
            lock_hi_n = (cls == CLS_HI);
          end
        end
        ST_LOCKED: begin
          hp_n = cnt;
          if (cls != (lock_hi ? CLS_HI : CLS_LO)) begin
            state_n = ST_ACQUIRE;
            cand_n  = cls;
            mc_n    = (cls != CLS_NONE) ? MC_W'(1) : '0;
          end
        end
        default: begin
          state_n = ST_SILENT;
          cand_n  = CLS_NONE;
          mc_n    = '0;
        end
      endcase
    end else if (cnt == CNT_MAX - CNT_W'(1)) begin
      // Counter is about to saturate: the tone has gone quiet.
      state_n = ST_SILENT;
      cand_n  = CLS_NONE;
      mc_n    = '0;
    end
  end

  // State, measurement and change-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_SILENT;
      cand        <= CLS_NONE;
      mc          <= '0;
      lock_hi     <= 1'b0;
      half_period <= '0;
      tone_change <= 1'b0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      mc          <= mc_n;
      lock_hi     <= lock_hi_n;
      half_period <= hp_n;
      tone_change <= (state_n == ST_LOCKED) != (state == ST_LOCKED);
    end
  end

  assign tone_valid = (state == ST_LOCKED);
  assign tone_hi    = tone_valid & lock_hi;

endmodule

// File: tb/tb_tone_detect.sv
// tb_tone_detect: directed stimulus for tone_detect with a scoreboard.
// Small parameters keep the run short: 10-bit counter (saturates at 1023),
// low tone half-period 200, high 100, tolerance 8, lock after 4 matches,
// glitch threshold 20. Each expected tone_change event (new tone_valid,
// tone_hi, half_period and the cycle it must appear in) is queued by the
// stimulus; the monitor pops one entry per tone_change cycle.
module tb_tone_detect;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1023;
  localparam int LO      = 200;
  localparam int HI      = 100;

  typedef struct {
    logic valid;
    logic hi;
    int   hp;
    int   cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             tone_in;
  logic             tone_valid;
  logic             tone_hi;
  logic [CNT_W-1:0] half_period;
  logic             tone_change;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   last_tog = 0;
  exp_t sb[$];

  tone_detect #(
    .CNT_W     (CNT_W),
    .HALF_LO   (LO),
    .HALF_HI   (HI),
    .TOL       (8),
    .STABLE_CNT(4),
    .MIN_HALF  (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tone_in    (tone_in),
    .tone_valid (tone_valid),
    .tone_hi    (tone_hi),
    .half_period(half_period),
    .tone_change(tone_change)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Issue n edges, each spaced `half` cycles after the previous one.
  task automatic run(input int half, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (half) @(negedge clk);
      tone_in  = ~tone_in;
      last_tog = cyc;
    end
  endtask

  // Queue an event expected 3 cycles after a toggle issued `half` cycles from now.
  task automatic expect_after(input logic v, input logic h, input int hp, input int half);
    exp_t e;
    e.valid = v;
    e.hi    = h;
    e.hp    = hp;
    e.cyc   = cyc + half + 3;
    sb.push_back(e);
  endtask

  // Monitor: every tone_change cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && tone_change) begin
      if (sb.size() == 0) begin
        check("unexpected_tone_change", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("chg_valid", int'(tone_valid), int'(e.valid));
        check("chg_hi", int'(tone_hi), int'(e.hi));
        check("chg_half_period", int'(half_period), e.hp);
        check("chg_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(tone_valid), 0);
    check("rst_hi", int'(tone_hi), 0);
    check("rst_half_period", int'(half_period), 0);
    check("rst_change", int'(tone_change), 0);
    rst = 1'b0;

    // Low tone lock: first edge starts, four more lock.
    run(LO, 1);
    run(LO, 3);
    expect_after(1'b1, 1'b0, LO, LO);
    run(LO, 1);
    run(LO, 2);
    repeat (5) @(negedge clk);
    check("lo_valid", int'(tone_valid), 1);
    check("lo_hi", int'(tone_hi), 0);

    // Reset in the middle of a locked tone.
    repeat (50) @(negedge clk);
    rst     = 1'b1;
    tone_in = 1'b0;
    #1;
    check("midrst_valid", int'(tone_valid), 0);
    check("midrst_hi", int'(tone_hi), 0);
    check("midrst_half_period", int'(half_period), 0);
    check("midrst_change", int'(tone_change), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run(LO, 1);
    run(LO, 3);
    expect_after(1'b1, 1'b0, LO, LO);
    run(LO, 1);
    run(LO, 2);

    // Switch to high tone, then back to low.
    expect_after(1'b0, 1'b0, HI, HI);
    run(HI, 1);
    run(HI, 2);
    expect_after(1'b1, 1'b1, HI, HI);
    run(HI, 1);
    run(HI, 2);
    repeat (5) @(negedge clk);
    check("hi_half_period", int'(half_period), HI);
    check("hi_hi", int'(tone_hi), 1);
    expect_after(1'b0, 1'b0, LO, LO - 5);
    run(LO - 5, 1);
    run(LO, 2);
    expect_after(1'b1, 1'b0, LO, LO);
    run(LO, 1);

    // Silence: tone_valid falls when the counter reaches saturation.
    begin
      exp_t e;
      e.valid = 1'b0;
      e.hi    = 1'b0;
      e.hp    = LO;
      e.cyc   = last_tog + 2 + CNT_MAX;
      sb.push_back(e);
    end
    repeat (CNT_MAX + 20) @(negedge clk);
    check("silent_valid", int'(tone_valid), 0);

    // Tolerance: +8 locks, +9 is no tone.
    run(LO + 8, 1);
    run(LO + 8, 3);
    expect_after(1'b1, 1'b0, LO + 8, LO + 8);
    run(LO + 8, 1);
    expect_after(1'b0, 1'b0, LO + 9, LO + 9);
    run(LO + 9, 1);
    run(LO + 9, 6);
    repeat (5) @(negedge clk);
    check("tol_out_valid", int'(tone_valid), 0);
    check("tol_out_half_period", int'(half_period), LO + 9);

    // High tone lower tolerance edge: -8 locks high, -9 drops out.
    run(HI - 8, 3);
    expect_after(1'b1, 1'b1, HI - 8, HI - 8);
    run(HI - 8, 1);
    expect_after(1'b0, 1'b0, HI - 9, HI - 9);
    run(HI - 9, 1);

    // Off-tone input never locks.
    run(150, 8);
    repeat (5) @(negedge clk);
    check("off_valid", int'(tone_valid), 0);
    check("off_half_period", int'(half_period), 150);

    // Lock low, then a 10-cycle pulse starting 5 cycles after a real edge.
    run(LO, 3);
    expect_after(1'b1, 1'b0, LO, LO);
    run(LO, 1);
`ifndef TONE_GLITCH_FILTER_EN
    expect_after(1'b0, 1'b0, 5, 5);
`endif
    repeat (5) @(negedge clk);
    tone_in = ~tone_in;
    repeat (10) @(negedge clk);
    tone_in = ~tone_in;
    repeat (LO - 15) @(negedge clk);
    tone_in = ~tone_in;
`ifdef TONE_GLITCH_FILTER_EN
    run(LO, 4);
    repeat (5) @(negedge clk);
    check("glitch_valid", int'(tone_valid), 1);
    check("glitch_half_period", int'(half_period), LO);
`else
    repeat (5) @(negedge clk);
    check("glitch_valid", int'(tone_valid), 0);
    check("glitch_half_period", int'(half_period), LO - 15);
    run(LO - 5, 0);
    run(LO, 3);
    expect_after(1'b1, 1'b0, LO, LO);
    run(LO, 1);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
